// File: rtl/operand_fetch.sv
// Operand fetch stage: register file with writeback bypass feeding a single-entry
// pipeline register of ALU operands, with valid/ready handshakes on both sides.
module operand_fetch #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [4:0]      rd_addr,
  input  logic [3:0]      alu_op,
  input  logic            use_imm,
  input  logic [XLEN-1:0] imm,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic [4:0]      rd_addr_q,
  output logic [3:0]      alu_op_q
);

  logic [XLEN-1:0] rf_q [NREG];

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [4:0]      rd_addr_d;
  logic [3:0]      alu_op_d;
  logic [4:0]      src1_q, src1_d;
  logic [4:0]      src2_q, src2_d;
  logic            use_imm_q, use_imm_d;
  logic            capture;

  // A source matching this cycle's writeback sees the new value, not the stale entry.
  function automatic logic [XLEN-1:0] read_src(input logic [4:0] addr);
    if (addr == '0 || int'(addr) >= NREG) return '0;
    if (wb_en && wb_addr == addr)         return wb_data;
    return rf_q[addr];
  endfunction

  function automatic logic wb_hits(input logic [4:0] addr);
    return wb_en && (addr != '0) && (wb_addr == addr);
  endfunction

  assign in_ready = !out_valid_q || out_ready;
  assign capture  = in_valid && in_ready;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    out_valid_d = out_valid_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_addr_d   = rd_addr_q;
    alu_op_d    = alu_op_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    use_imm_d   = use_imm_q;

    if (capture) begin
      out_valid_d = 1'b1;
      rs1_d       = read_src(rs1_addr);
      rs2_d       = use_imm ? imm : read_src(rs2_addr);
      rd_addr_d   = rd_addr;
      alu_op_d    = alu_op;
      src1_d      = rs1_addr;
      src2_d      = rs2_addr;
      use_imm_d   = use_imm;
    end else if (out_valid_q) begin
      if (out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        // A stalled instruction must not leave with an operand overwritten behind it.
        if (wb_hits(src1_q))               rs1_d = wb_data;
        if (!use_imm_q && wb_hits(src2_q)) rs2_d = wb_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the register file is reset explicitly because it must read 0 after reset;
      // plain storage arrays are normally left unreset so they map onto RAM.
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_en && wb_addr != '0 && int'(wb_addr) < NREG) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_addr_q   <= '0;
      alu_op_q    <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      use_imm_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      out_valid_q <= out_valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_addr_q   <= rd_addr_d;
      alu_op_q    <= alu_op_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      use_imm_q   <= use_imm_d;
    end
  end

  assign out_valid = out_valid_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed, table-driven bench for operand_fetch: writeback, bypass, immediate,
// x0 handling, back-to-back issue, stall behaviour and asynchronous reset.
module tb_operand_fetch;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready;
  logic [4:0]      rs1_addr, rs2_addr, rd_addr;
  logic [3:0]      alu_op;
  logic            use_imm;
  logic [XLEN-1:0] imm;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] rs1, rs2;
  logic [4:0]      rd_addr_q;
  logic [3:0]      alu_op_q;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  operand_fetch #(.XLEN(XLEN), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .alu_op(alu_op), .use_imm(use_imm), .imm(imm),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .rs1(rs1), .rs2(rs2), .rd_addr_q(rd_addr_q), .alu_op_q(alu_op_q)
  );

  typedef struct {
    logic        iv;
    logic [4:0]  ra1, ra2, rd;
    logic [3:0]  op;
    logic        ui;
    logic [31:0] imm;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ordy;
    logic        e_ir, e_ov;
    logic [31:0] e_rs1, e_rs2;
    logic [4:0]  e_rd;
    logic [3:0]  e_op;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic iv, input logic [4:0] ra1, input logic [4:0] ra2, input logic [4:0] rd,
    input logic [3:0] op, input logic ui, input logic [31:0] im,
    input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic ordy,
    input logic e_ir, input logic e_ov, input logic [31:0] e_rs1, input logic [31:0] e_rs2,
    input logic [4:0] e_rd, input logic [3:0] e_op);
    vec_t v;
    v.iv = iv; v.ra1 = ra1; v.ra2 = ra2; v.rd = rd; v.op = op; v.ui = ui; v.imm = im;
    v.we = we; v.wa = wa; v.wd = wd; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_rs1 = e_rs1; v.e_rs2 = e_rs2; v.e_rd = e_rd; v.e_op = e_op;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid = v.iv; rs1_addr = v.ra1; rs2_addr = v.ra2; rd_addr = v.rd; alu_op = v.op;
    use_imm = v.ui; imm = v.imm; wb_en = v.we; wb_addr = v.wa; wb_data = v.wd;
    out_ready = v.ordy;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    //            iv ra1 ra2 rd  op ui imm           we wa wd            ordy ir ov rs1           rs2           rd  op
    vecs[0]  = mk(0, 0,  0,  0,  0, 0, 0,            1, 1, 32'h2,        1,   1, 0, 0,            0,            0,  0);
    vecs[1]  = mk(0, 0,  0,  0,  0, 0, 0,            1, 2, 32'h1,        1,   1, 0, 0,            0,            0,  0);
    vecs[2]  = mk(1, 1,  2,  7,  3, 0, 0,            0, 0, 0,            1,   1, 1, 32'h2,        32'h1,        7,  3);
    vecs[3]  = mk(1, 3,  1,  8,  4, 0, 0,            1, 3, 32'hFFFFFFFE, 1,   1, 1, 32'hFFFFFFFE, 32'h2,        8,  4);
    vecs[4]  = mk(0, 0,  0,  0,  0, 0, 0,            1, 0, 32'h55,       1,   1, 0, 32'hFFFFFFFE, 32'h2,        8,  4);
    vecs[5]  = mk(1, 0,  0,  9,  5, 0, 0,            0, 0, 0,            1,   1, 1, 0,            0,            9,  5);
    vecs[6]  = mk(1, 1,  5,  10, 6, 1, 32'hFFFFFFFF, 1, 5, 32'h1234,     1,   1, 1, 32'h2,        32'hFFFFFFFF, 10, 6);
    vecs[7]  = mk(1, 5,  3,  11, 7, 0, 0,            0, 0, 0,            1,   1, 1, 32'h1234,     32'hFFFFFFFE, 11, 7);
    vecs[8]  = mk(1, 6,  6,  12, 8, 0, 0,            1, 6, 32'hA5A5,     1,   1, 1, 32'hA5A5,     32'hA5A5,     12, 8);
    vecs[9]  = mk(1, 4,  4,  13, 9, 0, 0,            0, 0, 0,            1,   1, 1, 0,            0,            13, 9);
    vecs[10] = mk(1, 1,  2,  14, 10, 0, 0,           1, 4, 32'h7,        0,   0, 1, 32'h7,        32'h7,        13, 9);
    vecs[11] = mk(1, 1,  2,  14, 10, 0, 0,           0, 0, 0,            0,   0, 1, 32'h7,        32'h7,        13, 9);
    vecs[12] = mk(1, 1,  5,  14, 10, 1, 32'h10,      0, 0, 0,            1,   1, 1, 32'h2,        32'h10,       14, 10);
    vecs[13] = mk(0, 0,  0,  0,  0, 0, 0,            1, 5, 32'h99,       0,   0, 1, 32'h2,        32'h10,       14, 10);
    vecs[14] = mk(0, 0,  0,  0,  0, 0, 0,            1, 1, 32'h77,       0,   0, 1, 32'h77,       32'h10,       14, 10);
    vecs[15] = mk(0, 0,  0,  0,  0, 0, 0,            0, 0, 0,            1,   1, 0, 32'h77,       32'h10,       14, 10);
    vecs[16] = mk(0, 0,  0,  0,  0, 0, 0,            1, 1, 32'h88,       0,   1, 0, 32'h77,       32'h10,       14, 10);

    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 0);
    check("reset in_ready",  32'(in_ready),  1);
    check("reset rs1",       rs1,            0);
    check("reset rs2",       rs2,            0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("v%0d rs1", i),       rs1,            vecs[i].e_rs1);
      check($sformatf("v%0d rs2", i),       rs2,            vecs[i].e_rs2);
      check($sformatf("v%0d rd_addr_q", i), 32'(rd_addr_q), 32'(vecs[i].e_rd));
      check($sformatf("v%0d alu_op_q", i),  32'(alu_op_q),  32'(vecs[i].e_op));
    end

    // Stall an instruction reading x1 (=0x88), then reset asynchronously mid-cycle.
    @(negedge clk);
    drive(mk(1, 1, 2, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("pre-reset out_valid", 32'(out_valid), 1);
    check("pre-reset rs1",       rs1,            32'h88);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", 32'(out_valid), 0);
    check("async reset rs1",       rs1,            0);
    check("async reset rd_addr_q", 32'(rd_addr_q), 0);
    check("async reset in_ready",  32'(in_ready),  1);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Registers written before reset must now read back as zero.
    @(negedge clk);
    drive(mk(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    #1;
    check("post-reset in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    check("post-reset x1", rs1, 0);
    check("post-reset x2", rs2, 0);
    check("post-reset out_valid", 32'(out_valid), 1);
    @(negedge clk);
    drive(mk(1, 5, 6, 2, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("post-reset x5", rs1, 0);
    check("post-reset x6", rs2, 0);

    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
    check("final drain out_valid", 32'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
